// File: rtl/tl_ul_pkg.sv
// TileLink-UL field widths, opcode constants and channel payload structs
// shared by the buffer top, its queues and the bench.
package tl_ul_pkg;

  localparam int unsigned TL_AW     = 30;
  localparam int unsigned TL_DW     = 32;
  localparam int unsigned TL_MW     = 4;
  localparam int unsigned TL_SZW    = 2;
  localparam int unsigned TL_SRCW   = 1;
  localparam int unsigned TL_SNKW   = 1;
  localparam int unsigned TL_A_OPW  = 3;
  localparam int unsigned TL_A_PRMW = 3;
  localparam int unsigned TL_D_OPW  = 3;
  localparam int unsigned TL_D_PRMW = 2;

  localparam logic [TL_A_OPW-1:0] OP_PUT_FULL        = 3'd0;
  localparam logic [TL_A_OPW-1:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [TL_A_OPW-1:0] OP_GET             = 3'd4;
  localparam logic [TL_D_OPW-1:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [TL_D_OPW-1:0] OP_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [TL_A_OPW-1:0]  opcode;
    logic [TL_A_PRMW-1:0] param;
    logic [TL_SZW-1:0]    size;
    logic [TL_SRCW-1:0]   source;
    logic [TL_AW-1:0]     address;
    logic [TL_MW-1:0]     mask;
    logic [TL_DW-1:0]     data;
    logic                 corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [TL_D_OPW-1:0]  opcode;
    logic [TL_D_PRMW-1:0] param;
    logic [TL_SZW-1:0]    size;
    logic [TL_SRCW-1:0]   source;
    logic [TL_SNKW-1:0]   sink;
    logic                 denied;
    logic [TL_DW-1:0]     data;
    logic                 corrupt;
  } tl_d_t;

endpackage

// File: rtl/tl_queue2.sv
// Two-entry registered FIFO: no flow-through, ready depends only on occupancy,
// full throughput at one entry.
module tl_queue2 #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_enq;
  logic         w_deq;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign w_enq   = i_valid && o_ready;
  assign w_deq   = o_valid && i_ready;
  assign o_count = r_count;

  // When empty, show the slot just dequeued so the payload holds its last value.
  assign o_data = o_valid ? r_mem[r_rptr] : r_mem[~r_rptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(w_enq) - 2'(w_deq);
    end
  end

  always_ff @(posedge clock) begin
    if (w_enq) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/tl_ul_buffer.sv
// TileLink-UL buffer: A channel always through a 2-entry queue; D channel
// queued only when TL_UL_BUFFER_D_QUEUE_EN is defined, else wired straight.
module tl_ul_buffer
  import tl_ul_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_a_valid,
  output logic                 in_a_ready,
  input  logic [TL_A_OPW-1:0]  in_a_opcode,
  input  logic [TL_A_PRMW-1:0] in_a_param,
  input  logic [TL_SZW-1:0]    in_a_size,
  input  logic [TL_SRCW-1:0]   in_a_source,
  input  logic [TL_AW-1:0]     in_a_address,
  input  logic [TL_MW-1:0]     in_a_mask,
  input  logic [TL_DW-1:0]     in_a_data,
  input  logic                 in_a_corrupt,
  output logic                 out_a_valid,
  input  logic                 out_a_ready,
  output logic [TL_A_OPW-1:0]  out_a_opcode,
  output logic [TL_A_PRMW-1:0] out_a_param,
  output logic [TL_SZW-1:0]    out_a_size,
  output logic [TL_SRCW-1:0]   out_a_source,
  output logic [TL_AW-1:0]     out_a_address,
  output logic [TL_MW-1:0]     out_a_mask,
  output logic [TL_DW-1:0]     out_a_data,
  output logic                 out_a_corrupt,
  input  logic                 out_d_valid,
  output logic                 out_d_ready,
  input  logic [TL_D_OPW-1:0]  out_d_opcode,
  input  logic [TL_D_PRMW-1:0] out_d_param,
  input  logic [TL_SZW-1:0]    out_d_size,
  input  logic [TL_SRCW-1:0]   out_d_source,
  input  logic [TL_SNKW-1:0]   out_d_sink,
  input  logic                 out_d_denied,
  input  logic [TL_DW-1:0]     out_d_data,
  input  logic                 out_d_corrupt,
  output logic                 in_d_valid,
  input  logic                 in_d_ready,
  output logic [TL_D_OPW-1:0]  in_d_opcode,
  output logic [TL_D_PRMW-1:0] in_d_param,
  output logic [TL_SZW-1:0]    in_d_size,
  output logic [TL_SRCW-1:0]   in_d_source,
  output logic [TL_SNKW-1:0]   in_d_sink,
  output logic                 in_d_denied,
  output logic [TL_DW-1:0]     in_d_data,
  output logic                 in_d_corrupt,
  output logic [1:0]           a_count,
  output logic [1:0]           d_count
);

  tl_a_t w_a_in;
  tl_a_t w_a_out;

  assign w_a_in = {in_a_opcode, in_a_param, in_a_size, in_a_source,
                   in_a_address, in_a_mask, in_a_data, in_a_corrupt};
  assign {out_a_opcode, out_a_param, out_a_size, out_a_source,
          out_a_address, out_a_mask, out_a_data, out_a_corrupt} = w_a_out;

  tl_queue2 #(.W($bits(tl_a_t))) u_a_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (in_a_valid),
    .o_ready (in_a_ready),
    .i_data  (w_a_in),
    .o_valid (out_a_valid),
    .i_ready (out_a_ready),
    .o_data  (w_a_out),
    .o_count (a_count)
  );

`ifdef TL_UL_BUFFER_D_QUEUE_EN
  tl_d_t w_d_in;
  tl_d_t w_d_out;

  assign w_d_in = {out_d_opcode, out_d_param, out_d_size, out_d_source,
                   out_d_sink, out_d_denied, out_d_data, out_d_corrupt};
  assign {in_d_opcode, in_d_param, in_d_size, in_d_source,
          in_d_sink, in_d_denied, in_d_data, in_d_corrupt} = w_d_out;

  tl_queue2 #(.W($bits(tl_d_t))) u_d_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (out_d_valid),
    .o_ready (out_d_ready),
    .i_data  (w_d_in),
    .o_valid (in_d_valid),
    .i_ready (in_d_ready),
    .o_data  (w_d_out),
    .o_count (d_count)
  );
`else
  // Unbuffered D: pure wires, zero latency.
  assign in_d_valid   = out_d_valid;
  assign out_d_ready  = in_d_ready;
  assign in_d_opcode  = out_d_opcode;
  assign in_d_param   = out_d_param;
  assign in_d_size    = out_d_size;
  assign in_d_source  = out_d_source;
  assign in_d_sink    = out_d_sink;
  assign in_d_denied  = out_d_denied;
  assign in_d_data    = out_d_data;
  assign in_d_corrupt = out_d_corrupt;
  assign d_count      = 2'd0;
`endif

endmodule

// File: doc/tl_ul_buffer.md
TL_UL_BUFFER -- requirements
Module: tl_ul_buffer

Interface
REQ-001 SHALL have port clock, input, 1 bit: sole clock, all state on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_a_valid/in_a_ready, input/output, 1 bit each: upstream A handshake.
REQ-004 SHALL have port in_a_opcode/param/size/source, input, 3/3/2/1 bits: upstream A control fields.
REQ-005 SHALL have port in_a_address/mask/data/corrupt, input, 30/4/32/1 bits: upstream A payload.
REQ-006 SHALL have port out_a_*, output (out_a_ready input), same names and widths as REQ-003..005: downstream A.
REQ-007 SHALL have port out_d_valid/out_d_ready, input/output, 1 bit each: downstream D handshake.
REQ-008 SHALL have port out_d_opcode/param/size/source/sink/denied, input, 3/2/2/1/1/1 bits: downstream D control.
REQ-009 SHALL have port out_d_data/corrupt, input, 32/1 bits: downstream D payload.
REQ-010 SHALL have port in_d_*, output (in_d_ready input), same names and widths as REQ-007..009: upstream D.
REQ-011 SHALL have port a_count/d_count, output, 2 bits each: current queue occupancy, 0..2.

Function
REQ-012 SHALL buffer A in a 2-entry FIFO, all fields (REQ-004/005) stored and forwarded unmodified, in order.
REQ-013 SHALL enqueue A when in_a_valid&&in_a_ready; dequeue when out_a_valid&&out_a_ready.
REQ-014 SHALL drive in_a_ready = (a_count!=2), independent of out_a_ready (no combinational ready path).
REQ-015 SHALL drive out_a_valid = (a_count!=0) from registers; no flow-through, minimum latency 1 cycle.
REQ-016 SHALL sustain 1 beat/cycle when a_count==1 and both sides handshake (count unchanged).
REQ-017 SHALL, at a_count==2 with dequeue, accept no enqueue that cycle (in_a_ready=0), count->1.
REQ-018 SHALL, at a_count==0, ignore out_a_ready; payload outputs hold last value.
REQ-019 SHALL use 1-bit read/write pointers wrapping 1->0; count = enq-deq update, never exceeding 0..2.
REQ-020 SHALL keep out_a_* bits stable while out_a_valid&&!out_a_ready.
REQ-021 SHALL apply REQ-012..020 identically to D (out_d_* in, in_d_* out, d_count) when REQ-029 enabled.

Reset
REQ-022 SHALL, on reset_n low, asynchronously clear pointers and counts: a_count=0, d_count=0, out_a_valid=0, in_d_valid=0.
REQ-023 SHALL drive in_a_ready=1 and out_d_ready=1 during and after reset.
REQ-024 SHALL discard any buffered beats on reset mid-operation; no beat emitted after release until new enqueue.
REQ-025 SHALL leave payload storage unreset; its contents are don't-care while count==0.
REQ-026 SHALL release reset synchronously-safe: first enqueue accepted on first rising edge with reset_n high.

Configuration
REQ-027 SHALL compile D-channel buffering under macro TL_UL_BUFFER_D_QUEUE_EN.
REQ-028 SHALL, without the macro, connect D combinationally (in_d_*=out_d_*, out_d_ready=in_d_ready), d_count tied 0.
REQ-029 SHALL, with the macro, instantiate the D FIFO per REQ-021; A channel always buffered.

Structure
REQ-030 SHALL place TileLink opcode constants (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1) and field widths in package tl_ul_pkg.
REQ-031 SHALL implement each FIFO as one parameterised sub-module tl_queue2 (data width parameter), instantiated per channel.

Verification
REQ-032 SHALL cover: reset, then in_a_valid=1 PutFull addr=0x1000_0000>>2, data=0xDEADBEEF, out_a_ready=1 -> out_a_valid high next cycle, same fields, a_count=1 then 0.
REQ-033 SHALL cover: out_a_ready=0, 3 enqueue attempts -> 2 accepted, in_a_ready=0, a_count=2; then out_a_ready=1 -> order preserved.
REQ-034 SHALL cover: continuous streaming 16 beats, both ready high -> 16 outputs in 17 cycles, no bubble after first.
REQ-035 SHALL cover: a_count=2, reset_n pulsed low mid-cycle -> out_a_valid=0 immediately, a_count=0, no stale beat after release.
REQ-036 SHALL cover: D AccessAckData data=0x12345678 denied=0 -> in_d_* after 1 cycle with macro, same cycle without, d_count 0 when disabled.
REQ-037 SHALL cover: backpressure hold, out_a_ready=0 for 5 cycles -> out_a_* bits unchanged throughout.
